// File: rtl/fpu_host_link.sv
// Host-side end of the FPU chip 10-bit pin protocol: serializes a request into five
// strobed beats on tx_out, then collects the two-beat 16-bit result from rx_in.
`timescale 1ns/1ps
module fpu_host_link #(
  parameter int BEAT_GAP = 0,
  parameter int TIMEOUT  = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic [3:0]  req_op,
  output logic [9:0]  tx_out,
  input  logic [9:0]  rx_in,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_data,
  output logic        resp_timeout,
  output logic        busy
);

  // Both handshakes transfer on a rising edge where valid && ready are high;
  // a producer keeps valid and its payload stable until that edge.
  localparam int GW = $clog2(BEAT_GAP + 2);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_LO, WAIT_HI, RESP} state_t;

  state_t         state_q, state_d;
  logic [15:0]    a_q, a_d, b_q, b_d;
  logic [3:0]     op_q, op_d;
  logic [2:0]     beat_q, beat_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic [TW-1:0]  to_q, to_d, to_inc;
  logic [7:0]     lo_q, lo_d;
  logic [9:0]     tx_d;
  logic           resp_valid_d, resp_timeout_d;
  logic [15:0]    resp_data_d;

  function automatic logic [9:0] beat_word(input logic [2:0] k, input logic [15:0] a,
                                           input logic [15:0] b, input logic [3:0] op);
    case (k)
      3'd0:    beat_word = {2'b10, a[7:0]};
      3'd1:    beat_word = {2'b10, a[15:8]};
      3'd2:    beat_word = {2'b10, b[7:0]};
      3'd3:    beat_word = {2'b10, b[15:8]};
      default: beat_word = {2'b11, 4'b0000, op};
    endcase
  endfunction

  assign to_inc = to_q + 1'b1;

  always_comb begin
    state_d        = state_q;
    a_d            = a_q;
    b_d            = b_q;
    op_d           = op_q;
    beat_d         = beat_q;
    gap_d          = gap_q;
    to_d           = to_q;
    lo_d           = lo_q;
    tx_d           = 10'h000;
    resp_valid_d   = resp_valid;
    resp_data_d    = resp_data;
    resp_timeout_d = resp_timeout;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          a_d     = req_a;
          b_d     = req_b;
          op_d    = req_op;
          beat_d  = 3'd0;
          gap_d   = '0;
          tx_d    = beat_word(3'd0, req_a, req_b, req_op);
          state_d = SEND;
        end
      end
      SEND: begin
        if (beat_q == 3'd4) begin
          to_d    = '0;
          state_d = WAIT_LO;
        end else if (gap_q != GW'(BEAT_GAP)) begin
          gap_d = gap_q + 1'b1;
        end else begin
          beat_d = beat_q + 3'd1;
          gap_d  = '0;
          tx_d   = beat_word(beat_q + 3'd1, a_q, b_q, op_q);
        end
      end
      WAIT_LO: begin
        // A high-byte beat here is out of order and deliberately ignored.
        if (rx_in[9] && !rx_in[8]) begin
          lo_d    = rx_in[7:0];
          to_d    = '0;
          state_d = WAIT_HI;
        end else if (to_inc == TW'(TIMEOUT)) begin
          resp_valid_d   = 1'b1;
          resp_data_d    = 16'h0000;
          resp_timeout_d = 1'b1;
          state_d        = RESP;
        end else begin
          to_d = to_inc;
        end
      end
      WAIT_HI: begin
        if (rx_in[9] && rx_in[8]) begin
          resp_valid_d   = 1'b1;
          resp_data_d    = {rx_in[7:0], lo_q};
          resp_timeout_d = 1'b0;
          state_d        = RESP;
        end else if (rx_in[9]) begin
          lo_d = rx_in[7:0];
          to_d = '0;
        end else if (to_inc == TW'(TIMEOUT)) begin
          resp_valid_d   = 1'b1;
          resp_data_d    = 16'h0000;
          resp_timeout_d = 1'b1;
          state_d        = RESP;
        end else begin
          to_d = to_inc;
        end
      end
      RESP: begin
        if (resp_valid && resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      beat_q       <= '0;
      gap_q        <= '0;
      to_q         <= '0;
      lo_q         <= '0;
      req_ready    <= 1'b1;
      tx_out       <= '0;
      resp_valid   <= 1'b0;
      resp_data    <= '0;
      resp_timeout <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      beat_q       <= beat_d;
      gap_q        <= gap_d;
      to_q         <= to_d;
      lo_q         <= lo_d;
      req_ready    <= (state_d == IDLE);
      tx_out       <= tx_d;
      resp_valid   <= resp_valid_d;
      resp_data    <= resp_data_d;
      resp_timeout <= resp_timeout_d;
      busy         <= (state_d != IDLE);
    end
  end

endmodule

// File: doc/fpu_host_link.md
Name: fpu_host_link

Overview:
- Host-side end of the 10-bit pin protocol used by the FPU chip.
- Accepts an operation request (two 16-bit operands plus a 4-bit opcode) on a valid/ready interface.
- Serializes the request into five strobed beats driven toward the chip's input pins, then deserializes the two-beat 16-bit result returned on the chip's output pins.
- Delivers the result on a valid/ready response interface. Used in the FPGA test harness that drives the tapeout.

Parameters:
- BEAT_GAP, 0, idle cycles (strobe low, data 0) inserted between consecutive transmit beats.
- TIMEOUT, 255, max cycles to wait in WAIT_LO or WAIT_HI before aborting; must be ≥1.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  request offered
- req_ready  output  1  high only in IDLE
- req_a  input  16  operand A
- req_b  input  16  operand B
- req_op  input  4  opcode
- tx_out  output  10  to chip io_in[9:0]: [9]=strobe, [8]=last, [7:0]=data
- rx_in  input  10  from chip io_out[9:0]: [9]=valid, [8]=hi-byte flag, [7:0]=data
- resp_valid  output  1  response available
- resp_ready  input  1  response consumed
- resp_data  output  16  result
- resp_timeout  output  1  qualifies resp_valid; 1 = no complete result received
- busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-high.
- Registered outputs: all outputs are registered.
- Reset values:
  - req_ready=1 (IDLE); tx_out=0; resp_valid=0; resp_data=0; resp_timeout=0; busy=0.
  - Internal state: beat and timeout counters cleared; request and capture registers cleared.
- Reset mid-operation: reset in any state returns to IDLE next cycle with the values above. A partial frame is abandoned; the chip side resynchronizes on the next frame.
- States: IDLE, SEND, WAIT_LO, WAIT_HI, RESP.
- IDLE:
  - On req_valid&&req_ready, latch req_a/req_b/req_op, clear beat counter, go to SEND.
  - tx_out=0.
- SEND:
  - Beat k (k=0..4) appears on tx_out in the cycle 1+k*(BEAT_GAP+1) after acceptance. Each beat has a one-cycle strobe ([9]=1).
  - Beat data:
    - k0: A[7:0]
    - k1: A[15:8]
    - k2: B[7:0]
    - k3: B[15:8]
    - k4: {4'b0, op}
  - last bit [8]=1 on k4 only.
  - Gap cycles drive tx_out=0.
  - The cycle after k4, tx_out=0, clear timeout counter, go to WAIT_LO.
- rx_in sampling: sampled only in WAIT_LO and WAIT_HI. rx_in activity in any other state is ignored.
- WAIT_LO:
  - rx_in[9]=1 with [8]=0: capture low byte, reset timeout counter, go to WAIT_HI.
  - rx_in[9]=1 with [8]=1: ignored (no capture, counter keeps running).
- WAIT_HI:
  - rx_in[9]=1 with [8]=1: capture high byte, go to RESP.
  - Another low-byte beat ([8]=0): overwrites the low byte and resets the timeout counter.
- Response on completion: resp_valid rises the cycle after the high byte is sampled, with resp_data={hi,lo} and resp_timeout=0.
- Timeout:
  - The timeout counter increments each cycle in WAIT_LO/WAIT_HI.
  - When the counter reaches TIMEOUT with no qualifying beat that cycle, go to RESP with resp_data=16'h0000 and resp_timeout=1.
  - A qualifying beat arriving in the same cycle the counter hits TIMEOUT wins; no timeout is raised.
- RESP:
  - Hold resp_valid/resp_data/resp_timeout stable until resp_valid&&resp_ready.
  - Next cycle: resp_valid=0, go to IDLE (req_ready=1).
  - Back-to-back requests are therefore separated by at least one IDLE cycle.
- Busy: busy=!IDLE.
- Request path while not in IDLE: req_ready=0, so req_valid is ignored.

Test Plan:
- Reset, then BEAT_GAP=0, A=16'h3C00, B=16'h4000, op=4'h1 -> tx_out in 5 consecutive cycles: 0x200, 0x23C, 0x200, 0x240, 0x301; req_ready=0 and busy=1 throughout; then tx_out=0.
- After the frame, drive rx_in=0x200 then 0x342 two cycles later, resp_ready=1 -> resp_valid one cycle after the hi beat, resp_data=16'h4200, resp_timeout=0; IDLE and req_ready=1 the following cycle.
- BEAT_GAP=2 with the same request -> beats at cycles 1,4,7,10,13 after acceptance; tx_out=0 in all gap cycles.
- TIMEOUT=8, no rx beats -> resp_valid with resp_timeout=1, resp_data=0 exactly 8 cycles after entering WAIT_LO. Variant: rx_in=0x200 at wait cycle 5 restarts the count, timeout 8 cycles later.
- In WAIT_LO drive 0x3AA (hi first) -> ignored. Then 0x211, 0x233, 0x3AA -> resp_data=16'hAA33. Hold resp_ready=0 for 4 cycles -> response held stable and req_ready stays 0.
- Assert reset during SEND beat k2 -> next cycle tx_out=0, req_ready=1, busy=0. A new request then sends a complete 5-beat frame from k0.
